// File: rtl/startup_pkg.sv
// Shared types and defaults for the PROGRAM request responder.
package startup_pkg;

    typedef enum logic [1:0] {
        WAIT_EOS,
        IDLE,
        QUIESCE,
        ACK
    } state_t;

    localparam int DEF_SYNC_STAGES    = 2;
    localparam int DEF_TIMEOUT_CYCLES = 1024;

endpackage

// File: rtl/startup_sync.sv
// Multi-flop synchronizer for an asynchronous level; async reset to 0.
module startup_sync #(
    parameter int STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_chain;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_chain <= '0;
        end else begin
            r_chain <= {r_chain[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_chain[STAGES-1];

endmodule

// File: rtl/startup_prog_responder.sv
// PREQ/PACK responder: quiesces user logic before acknowledging PROGRAM.
// Define STARTUP_TIMEOUT_EN to build the QUIESCE_ACK timeout and TIMEOUT_FLAG.
module startup_prog_responder
    import startup_pkg::*;
#(
    parameter int SYNC_STAGES    = DEF_SYNC_STAGES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic CLK,
    input  logic RST,
    input  logic EOS,
    input  logic PREQ,
    output logic PACK,
    output logic QUIESCE_REQ,
    input  logic QUIESCE_ACK,
    output logic BUSY,
    output logic TIMEOUT_FLAG
);

    if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("startup_prog_responder: parameter out of range");
    end

    logic   w_eos_s;
    logic   w_preq_s;
    state_t r_state;
    logic   r_pack;
    logic   r_qreq;
    logic   r_busy;

    startup_sync #(.STAGES(SYNC_STAGES)) u_sync_eos (
        .i_clk (CLK),
        .i_rst (RST),
        .i_d   (EOS),
        .o_q   (w_eos_s)
    );

    startup_sync #(.STAGES(SYNC_STAGES)) u_sync_preq (
        .i_clk (CLK),
        .i_rst (RST),
        .i_d   (PREQ),
        .o_q   (w_preq_s)
    );

`ifdef STARTUP_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] r_cnt;
    logic          r_tflag;

    assign TIMEOUT_FLAG = r_tflag;
`else
    assign TIMEOUT_FLAG = 1'b0;
`endif

    // Outputs are assigned alongside each transition so they track next-state.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= WAIT_EOS;
            r_pack  <= 1'b0;
            r_qreq  <= 1'b0;
            r_busy  <= 1'b1;
`ifdef STARTUP_TIMEOUT_EN
            r_cnt   <= '0;
            r_tflag <= 1'b0;
`endif
        end else begin
            unique case (r_state)
                WAIT_EOS: begin
                    if (w_eos_s) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                IDLE: begin
                    if (w_preq_s) begin
                        r_state <= QUIESCE;
                        r_qreq  <= 1'b1;
                        r_busy  <= 1'b1;
`ifdef STARTUP_TIMEOUT_EN
                        r_cnt   <= '0;
`endif
                    end
                end
                QUIESCE: begin
                    if (!w_preq_s) begin
                        r_state <= IDLE;
                        r_qreq  <= 1'b0;
                        r_busy  <= 1'b0;
`ifdef STARTUP_TIMEOUT_EN
                        r_cnt   <= '0;
`endif
                    end else if (QUIESCE_ACK) begin
                        r_state <= ACK;
                        r_pack  <= 1'b1;
                    end
`ifdef STARTUP_TIMEOUT_EN
                    else if (r_cnt == LAST) begin
                        r_state <= ACK;
                        r_pack  <= 1'b1;
                        r_tflag <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
`endif
                end
                ACK: begin
                    if (!w_preq_s) begin
                        r_state <= IDLE;
                        r_pack  <= 1'b0;
                        r_qreq  <= 1'b0;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= WAIT_EOS;
                    r_pack  <= 1'b0;
                    r_qreq  <= 1'b0;
                    r_busy  <= 1'b1;
                end
            endcase
        end
    end

    assign PACK        = r_pack;
    assign QUIESCE_REQ = r_qreq;
    assign BUSY        = r_busy;

endmodule

// File: tb/tb_startup_prog_responder.sv
// Directed plus randomized bench for startup_prog_responder against a behavioural model.
module tb_startup_prog_responder;

    localparam int S = 2;
    localparam int T = 8;
`ifdef STARTUP_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic CLK = 1'b0;
    logic RST, EOS, PREQ, QUIESCE_ACK;
    logic PACK, QUIESCE_REQ, BUSY, TIMEOUT_FLAG;

    int checks = 0;
    int failures = 0;

    startup_prog_responder #(.SYNC_STAGES(S), .TIMEOUT_CYCLES(T)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .EOS          (EOS),
        .PREQ         (PREQ),
        .PACK         (PACK),
        .QUIESCE_REQ  (QUIESCE_REQ),
        .QUIESCE_ACK  (QUIESCE_ACK),
        .BUSY         (BUSY),
        .TIMEOUT_FLAG (TIMEOUT_FLAG)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Model: sync chains as delay queues, handshake as plain booleans.
    bit eq[$];
    bit pq[$];
    bit m_up, m_req, m_ack, m_to;
    int m_wait;

    function automatic void m_reset();
        eq = {};
        pq = {};
        for (int i = 0; i < S; i++) begin
            eq.push_back(1'b0);
            pq.push_back(1'b0);
        end
        m_up = 0; m_req = 0; m_ack = 0; m_to = 0; m_wait = 0;
    endfunction

    function automatic void m_step();
        bit es, ps;
        es = eq[S-1];
        ps = pq[S-1];
        eq.push_front(EOS);
        void'(eq.pop_back());
        pq.push_front(PREQ);
        void'(pq.pop_back());
        if (!m_up) begin
            if (es) m_up = 1;
        end else if (!m_req) begin
            if (ps) begin
                m_req = 1;
                m_wait = 0;
            end
        end else if (!m_ack) begin
            if (!ps) m_req = 0;
            else if (QUIESCE_ACK) m_ack = 1;
            else if (TO_EN && m_wait == T - 1) begin
                m_ack = 1;
                m_to = 1;
            end else m_wait++;
        end else if (!ps) begin
            m_req = 0;
            m_ack = 0;
        end
    endfunction

    task automatic step(input string tag);
        @(posedge CLK);
        #1;
        if (RST) m_reset();
        else m_step();
        chk({tag, ".pack"}, PACK, m_ack);
        chk({tag, ".qreq"}, QUIESCE_REQ, m_req);
        chk({tag, ".busy"}, BUSY, !m_up || m_req);
        chk({tag, ".tflag"}, TIMEOUT_FLAG, m_to);
    endtask

    task automatic wait_qreq(input string tag);
        int n = 0;
        while (!QUIESCE_REQ && n < 10) begin
            step(tag);
            n++;
        end
        chk({tag, ".qreq_up"}, QUIESCE_REQ, 1);
    endtask

    initial begin
        int k;
        bit saw_req, saw_pack;

        RST = 1; EOS = 0; PREQ = 0; QUIESCE_ACK = 0;
        m_reset();
        #12;
        chk("rst.pack", PACK, 0);
        chk("rst.qreq", QUIESCE_REQ, 0);
        chk("rst.busy", BUSY, 1);
        chk("rst.tflag", TIMEOUT_FLAG, 0);
        RST = 0;

        PREQ = 1;
        for (int i = 0; i < 20; i++) begin
            step("noeos");
            chk("noeos.busy_c", BUSY, 1);
            chk("noeos.qreq_c", QUIESCE_REQ, 0);
        end

        PREQ = 0; EOS = 1;
        repeat (5) step("eos");
        chk("eos.idle", BUSY, 0);
        PREQ = 1;
        step("hs");
        step("hs");
        chk("hs.qreq_early", QUIESCE_REQ, 0);
        step("hs");
        chk("hs.qreq_n2", QUIESCE_REQ, 1);
        repeat (2) step("hs");
        QUIESCE_ACK = 1;
        step("hs");
        chk("hs.pack_m", PACK, 1);
        QUIESCE_ACK = 0;
        repeat (5) step("hs");
        PREQ = 0;
        step("hs");
        step("hs");
        chk("hs.pack_hold", PACK, 1);
        step("hs");
        chk("hs.pack_fall", PACK, 0);
        chk("hs.qreq_fall", QUIESCE_REQ, 0);
        repeat (3) step("hs");

        PREQ = 1;
        wait_qreq("coin");
        repeat (T - 1) step("coin");
        chk("coin.pack_early", PACK, 0);
        QUIESCE_ACK = 1;
        step("coin");
        chk("coin.pack", PACK, 1);
        chk("coin.tflag", TIMEOUT_FLAG, 0);
        QUIESCE_ACK = 0; PREQ = 0;
        repeat (4) step("coin");

        saw_req = 0; saw_pack = 0;
        PREQ = 1;
        for (int i = 0; i < 10; i++) begin
            if (i == 4) PREQ = 0;
            step("abort");
            saw_req |= QUIESCE_REQ;
            saw_pack |= PACK;
        end
        chk("abort.saw_req", saw_req, 1);
        chk("abort.saw_pack", saw_pack, 0);
        chk("abort.idle", BUSY, 0);

        PREQ = 1;
        wait_qreq("to");
        k = 0;
        while (!PACK && k < 100) begin
            step("to");
            k++;
        end
        if (TO_EN) begin
            chk("to.latency", k, T);
            chk("to.flag", TIMEOUT_FLAG, 1);
        end else begin
            chk("noto.pack", PACK, 0);
            chk("noto.flag", TIMEOUT_FLAG, 0);
        end
        PREQ = 0;
        repeat (4) step("to");
        PREQ = 1;
        wait_qreq("clean");
        QUIESCE_ACK = 1;
        step("clean");
        chk("clean.pack", PACK, 1);
        chk("clean.sticky", TIMEOUT_FLAG, TO_EN);
        QUIESCE_ACK = 0; PREQ = 0;
        repeat (4) step("clean");

        PREQ = 1; QUIESCE_ACK = 1;
        k = 0;
        while (!PACK && k < 10) begin
            step("arst");
            k++;
        end
        chk("arst.pack_pre", PACK, 1);
        #2;
        RST = 1;
        #1;
        chk("arst.pack", PACK, 0);
        chk("arst.qreq", QUIESCE_REQ, 0);
        chk("arst.busy", BUSY, 1);
        chk("arst.tflag", TIMEOUT_FLAG, 0);
        m_reset();
        EOS = 0;
        step("arst");
        RST = 0;
        repeat (10) step("arst_wait");
        chk("arst.no_pack", PACK, 0);
        EOS = 1;
        k = 0;
        while (!PACK && k < 12) begin
            step("arst_eos");
            k++;
        end
        chk("arst.pack_again", PACK, 1);
        QUIESCE_ACK = 0;

        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 7) == 0) PREQ = ~PREQ;
            QUIESCE_ACK = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 15) == 0) EOS = ~EOS;
            RST = ($urandom_range(0, 149) == 0);
            step("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/startup_prog_responder.md
# startup_prog_responder

Fabric-side responder for the configuration-logic PROGRAM request handshake. Monitors the PREQ output of the 7-series startup primitive, asks user logic to quiesce, then returns PACK so reconfiguration may proceed. Sits directly beside the startup-primitive wrapper in the top level, ahead of any user reset tree.

## Interface
- SYNC_STAGES, 2: synchronizer depth for PREQ and EOS; range 2..4.
- TIMEOUT_CYCLES, 1024: maximum CLK cycles spent waiting for QUIESCE_ACK; must be at least 1.
- CLK  in  1  user clock, single clock domain.
- RST  in  1  asynchronous, active-high reset.
- EOS  in  1  end-of-startup from the primitive; asynchronous to CLK.
- PREQ  in  1  PROGRAM request from the primitive; asynchronous to CLK.
- PACK  out  1  PROGRAM acknowledge to the primitive; registered.
- QUIESCE_REQ  out  1  request to user logic to reach a safe state; registered.
- QUIESCE_ACK  in  1  user logic is safe; synchronous to CLK, level.
- BUSY  out  1  high in any state other than IDLE.
- TIMEOUT_FLAG  out  1  sticky; set when the acknowledge was forced by timeout.

## Operation
- EOS and PREQ each pass through a SYNC_STAGES flop chain, giving eos_s and preq_s. All decisions use only the synchronized versions.
- FSM states:
  - WAIT_EOS, the reset state: go to IDLE when eos_s=1.
  - IDLE: go to QUIESCE when preq_s=1.
  - QUIESCE: QUIESCE_REQ=1 and the timeout counter runs.
    - QUIESCE_ACK=1 goes to ACK.
    - Counter reaching TIMEOUT_CYCLES-1 goes to ACK and sets TIMEOUT_FLAG.
    - preq_s=0 aborts to IDLE, with QUIESCE_REQ low and the counter cleared.
  - ACK: PACK=1 and QUIESCE_REQ=1. Go to IDLE when preq_s=0; PACK and QUIESCE_REQ then fall together.
- Precedence in QUIESCE: abort first, then QUIESCE_ACK, then timeout. If QUIESCE_ACK and the last timeout cycle coincide, go to ACK without setting TIMEOUT_FLAG.
- Timeout counter:
  - Width $clog2(TIMEOUT_CYCLES+1); it never wraps.
  - Cleared on entry to QUIESCE.
  - Holds its value outside QUIESCE.
- If preq_s is already high when eos_s rises: WAIT_EOS goes to IDLE, then to QUIESCE on the next edge. No request is lost.
- eos_s falling after startup is ignored; there is no return to WAIT_EOS except through RST.
- TIMEOUT_FLAG is cleared only by RST.
- BUSY is high in WAIT_EOS, QUIESCE and ACK.

## Timing
- Reset values: state WAIT_EOS, PACK=0, QUIESCE_REQ=0, BUSY=1, TIMEOUT_FLAG=0, counter 0, synchronizer flops 0.
- All outputs are registered and derived from next-state.
- PREQ rising sampled at edge N gives preq_s=1 after edge N+SYNC_STAGES-1. QUIESCE_REQ rises after edge N+SYNC_STAGES.
- QUIESCE_ACK high at edge M (while in QUIESCE) gives PACK=1 after edge M.
- Timeout path: PACK rises exactly TIMEOUT_CYCLES edges after QUIESCE_REQ rises.
- PREQ fall gives PACK=0 and QUIESCE_REQ=0 SYNC_STAGES edges after the first low sample.
- RST assertion mid-handshake clears PACK and QUIESCE_REQ immediately (asynchronously). After reset the block waits for EOS again.

## Configuration
- STARTUP_TIMEOUT_EN defined: timeout counter and TIMEOUT_FLAG are active as described above.
- STARTUP_TIMEOUT_EN undefined:
  - No counter is built.
  - QUIESCE waits indefinitely for QUIESCE_ACK or abort.
  - TIMEOUT_FLAG is tied to 0.
  - TIMEOUT_CYCLES is ignored.

## Structure
- Shared package startup_pkg holds:
  - the state enum (WAIT_EOS, IDLE, QUIESCE, ACK);
  - the default constants for SYNC_STAGES and TIMEOUT_CYCLES.
- Sub-module startup_sync: a parameterized SYNC_STAGES flop chain with async reset to 0. It is instantiated twice, once for EOS and once for PREQ.
- FSM and counter live in startup_prog_responder itself.

## Test plan
All scenarios use SYNC_STAGES=2 and TIMEOUT_CYCLES=8.
- Reset, then EOS=0 with PREQ=1 for 20 cycles: PACK=0, QUIESCE_REQ=0, BUSY=1 throughout.
- EOS=1, PREQ rises at edge 10, QUIESCE_ACK=1 at edge 15:
  - QUIESCE_REQ=1 after edge 12; PACK=1 after edge 15.
  - PREQ low at edge 30 gives PACK=0 after edge 32.
- QUIESCE_ACK held 0: PACK rises exactly 8 edges after QUIESCE_REQ, and TIMEOUT_FLAG=1 stays set through a later clean handshake.
- QUIESCE_ACK asserted on the 8th QUIESCE cycle: PACK=1, TIMEOUT_FLAG=0.
- PREQ pulses for 4 cycles with no ACK: QUIESCE_REQ rises, then falls after the abort; PACK never asserts; FSM returns to IDLE.
- RST asserted while PACK=1: PACK=0 within the same cycle; the block then requires EOS again before responding.
- With STARTUP_TIMEOUT_EN undefined: no ACK for 100 cycles gives PACK=0 and TIMEOUT_FLAG=0.
